// File: rtl/wb_timer.sv
// Wishbone B4 classic responder holding the RISC-V machine timer (mtime, mtimecmp) and msip.
// Define WB_TIMER_ERR_EN to terminate unmapped offsets with wbs_err_o instead of wbs_ack_o.
`timescale 1ns/1ps
module wb_timer #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        xint_mtip_o,
    output logic        xint_msip_o
);

    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] prescale_q, prescale_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        mtip_q, mtip_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;

    logic        req;
    logic        mapped;
    logic        wr_en;
    logic        tick;
    logic [2:0]  offset;
    logic [31:0] rdata;
    logic        unused_addr;

    assign unused_addr = ^{wbs_addr_i[31:5], wbs_addr_i[1:0]};
    assign offset      = wbs_addr_i[4:2];

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = sel[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        end
        return res;
    endfunction

    always_comb begin
        mapped = 1'b1;
        rdata  = 32'd0;
        case (offset)
            3'd0:    rdata = {31'd0, msip_q};
            3'd2:    rdata = mtimecmp_q[31:0];
            3'd3:    rdata = mtimecmp_q[63:32];
            3'd4:    rdata = mtime_q[31:0];
            3'd5:    rdata = mtime_q[63:32];
            default: mapped = 1'b0;
        endcase
    end

    assign req   = (state_q == IDLE) && wbs_cyc_i && wbs_stb_i;
    assign wr_en = req && wbs_we_i && mapped;
    assign tick  = (prescale_q == DIV_LAST);

    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        dat_d      = 32'd0;
        prescale_d = tick ? 16'd0 : prescale_q + 16'd1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        // Compare registered values so mtip follows any change by one cycle.
        mtip_d     = (mtime_q >= mtimecmp_q);

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = RESP;
`ifdef WB_TIMER_ERR_EN
                    ack_d   = mapped;
`else
                    ack_d   = 1'b1;
`endif
                    if (!wbs_we_i && mapped) begin
                        dat_d = rdata;
                    end
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A write to either mtime half replaces the whole tick, including any carry.
        if (wr_en) begin
            case (offset)
                3'd0: if (wbs_sel_i[0]) msip_d = wbs_dat_i[0];
                3'd2: mtimecmp_d[31:0]  = byte_merge(mtimecmp_q[31:0],  wbs_dat_i, wbs_sel_i);
                3'd3: mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], wbs_dat_i, wbs_sel_i);
                3'd4: mtime_d = {mtime_q[63:32], byte_merge(mtime_q[31:0], wbs_dat_i, wbs_sel_i)};
                3'd5: mtime_d = {byte_merge(mtime_q[63:32], wbs_dat_i, wbs_sel_i), mtime_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            prescale_q <= 16'd0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            prescale_q <= prescale_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
        end
    end

`ifdef WB_TIMER_ERR_EN
    logic err_q, err_d;

    assign err_d = req && !mapped;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign wbs_err_o = err_q;
`else
    assign wbs_err_o = 1'b0;
`endif

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign xint_mtip_o = mtip_q;
    assign xint_msip_o = msip_q;

endmodule
